// File: rtl/fetch_responder_pkg.sv
// Shared types and helpers for the instruction-fetch responder: state encoding,
// instruction width and the byte-address legality check.
package fetch_responder_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] ZERO_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // A byte address is usable when it is word aligned and every bit above the
    // word index is clear.
    function automatic logic addr_in_range(input logic [15:0] addr,
                                           input int unsigned depth_log2);
        logic [15:0] hi;
        hi = addr >> (depth_log2 + 1);
        return (addr[0] == 1'b0) && (hi == 16'h0000);
    endfunction

endpackage

// File: rtl/fetch_responder_if.sv
// Fetch request/response, redirect and program-load signals between the PC
// stage (master) and the fetch responder (slave).
//
// Handshake: a request is taken on the rising edge where req_valid=1 and the
// responder can accept (not stalled, flush=0, ld_en=0). There is no ready
// signal; the PC stage holds while stall=1. rsp_valid is a one-cycle pulse and
// rsp_instr/rsp_addr/rsp_err are only meaningful in that cycle.
interface fetch_responder_if;

    logic        req_valid;
    logic [15:0] req_addr;
    logic        flush;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        stall;
    logic        rsp_valid;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, ld_en, ld_addr, ld_data,
        input  stall, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, ld_en, ld_addr, ld_data,
        output stall, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

endinterface

// File: rtl/fetch_responder_imem_array.sv
// Program store: 2**DEPTH_LOG2 words of 16 bits, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module imem_array
    import fetch_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [INSTR_W-1:0]    wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [INSTR_W-1:0]    rdata
);

    logic [INSTR_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-cycle write to raddr is seen only after the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_responder.sv
// Instruction-fetch responder: accepts a fetch, stalls the PC stage for the
// in-flight period and returns the stored word LATENCY cycles later.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    fetch_responder_if.slave    bus,
    output state_t              dbg_state
);

    localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic               accept;
    logic               addr_ok;
    logic               ld_ok;
    logic [INSTR_W-1:0] rd_word;

    assign ld_ok   = addr_in_range(bus.ld_addr, DEPTH_LOG2);
    assign addr_ok = addr_in_range(addr_q, DEPTH_LOG2);

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_imem (
        .clk   (clk),
        .we    (bus.ld_en & ld_ok),
        .waddr (bus.ld_addr[DEPTH_LOG2:1]),
        .wdata (bus.ld_data),
        .raddr (addr_q[DEPTH_LOG2:1]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                // A load owns the cycle; a flush drops any request presented with it.
                accept = bus.req_valid & ~bus.flush & ~bus.ld_en;
                if (accept) begin
                    addr_d = bus.req_addr;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is gated by reset so the PC stage never sees it while held in reset.
    assign bus.stall     = rst & ((state_q == WAIT) | bus.ld_en);
    assign bus.rsp_valid = (state_q == DONE) & ~bus.flush;
    assign bus.rsp_err   = bus.rsp_valid & ~addr_ok;
    assign bus.rsp_instr = (bus.rsp_valid & addr_ok) ? rd_word : ZERO_INSTR;
    assign bus.rsp_addr  = bus.rsp_valid ? addr_q : 16'h0000;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed and randomized checks of fetch_responder against a cycle-scheduled
// reference: a pending fetch is due LATENCY cycles after its request cycle.
module tb_fetch_responder;
    import fetch_responder_pkg::*;

    localparam int LAT = 2;
    localparam int DL2 = 8;
    localparam int NWORDS = 1 << DL2;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    fetch_responder_if bus ();

    fetch_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: program words plus at most one scheduled response.
    logic [15:0] mem_m [NWORDS];
    bit          pending;
    int          due;
    logic [15:0] p_addr;
    int          cyc;

    function automatic bit legal(input logic [15:0] a);
        return (a[0] == 1'b0) && (int'(a) < 2 * NWORDS);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic rv, input logic [15:0] ra, input logic fl,
                         input logic le, input logic [15:0] la, input logic [15:0] ld);
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.flush     = fl;
        bus.ld_en     = le;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Check the current cycle against the model, then advance model and clock.
    task automatic tick();
        bit          resp_now, busy, accept, e_valid, e_err, e_stall;
        logic [15:0] e_instr, e_addr;
        #1;
        if (!rst) pending = 0;
        resp_now = pending && (due == cyc);
        busy     = pending && (due > cyc);
        e_valid  = resp_now && !bus.flush;
        e_err    = e_valid && !legal(p_addr);
        e_instr  = (e_valid && !e_err) ? mem_m[p_addr[DL2:1]] : 16'h0000;
        e_addr   = e_valid ? p_addr : 16'h0000;
        e_stall  = rst && (busy || bus.ld_en);
        chk("stall",     16'(bus.stall),     16'(e_stall));
        chk("rsp_valid", 16'(bus.rsp_valid), 16'(e_valid));
        chk("rsp_err",   16'(bus.rsp_err),   16'(e_err));
        chk("rsp_instr", bus.rsp_instr,      e_instr);
        chk("rsp_addr",  bus.rsp_addr,       e_addr);
        if (rst) begin
            accept = !busy && bus.req_valid && !bus.flush && !bus.ld_en;
            if (bus.flush || resp_now) pending = 0;
            if (accept) begin
                pending = 1;
                due     = cyc + LAT;
                p_addr  = bus.req_addr;
            end
            if (bus.ld_en && legal(bus.ld_addr)) mem_m[bus.ld_addr[DL2:1]] = bus.ld_data;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra;
        pending = 0;
        due     = 0;
        p_addr  = 16'h0;
        cyc     = 0;
        rst     = 1'b0;
        idle();
        @(negedge clk);

        // Reset held for three cycles, then released.
        repeat (3) tick();
        chk("reset_state", 16'(dbg_state), 16'(IDLE));
        rst = 1'b1;
        tick();

        // Preload the whole store so every fetch returns a known word.
        for (int i = 0; i < NWORDS; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b1, 16'(2 * i), 16'($urandom));
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 16'hC123); tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0006, 16'hA001); tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 16'h1234); tick();

        // Single fetch.
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); #1 chk("t2_stall_t1", 16'(bus.stall), 16'h1); tick();
        #1 chk("t2_instr", bus.rsp_instr, 16'hC123);
        chk("t2_addr", bus.rsp_addr, 16'h0004); tick();
        #1 chk("t2_valid_t3", 16'(bus.rsp_valid), 16'h0); tick();

        // Back-to-back fetch, second request presented in the DONE cycle.
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); tick();
        drive(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0);
        #1 chk("t3_instr_a", bus.rsp_instr, 16'hC123);
        chk("t3_stall_t2", 16'(bus.stall), 16'h0); tick();
        idle(); #1 chk("t3_stall_t3", 16'(bus.stall), 16'h1); tick();
        #1 chk("t3_instr_b", bus.rsp_instr, 16'hA001); tick();
        tick();

        // Flush while waiting.
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0); tick();
        idle();
        #1 chk("t4_valid", 16'(bus.rsp_valid), 16'h0);
        chk("t4_state", 16'(dbg_state), 16'(IDLE)); tick();

        // Error responses and an ignored illegal load.
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); tick();
        #1 chk("t5_mis_err", 16'(bus.rsp_err), 16'h1);
        chk("t5_mis_instr", bus.rsp_instr, 16'h0000); tick();
        drive(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); tick();
        #1 chk("t5_oor_err", 16'(bus.rsp_err), 16'h1); tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0201, 16'hBEEF); tick();
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); tick();
        #1 chk("t5_store_kept", bus.rsp_instr, 16'h1234); tick();

        // Load landing during WAIT is seen by the pending fetch.
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0008, 16'h5555); tick();
        idle(); #1 chk("t6_ld_wait", bus.rsp_instr, 16'h5555); tick();

        // Reset in the middle of a fetch abandons it.
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0, 16'h0); tick();
        idle(); rst = 1'b0; tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t6_no_rsp", 16'(bus.rsp_valid), 16'h0);
            tick();
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = 16'({$urandom_range(0, NWORDS - 1), 1'b1});
                1:       ra = 16'($urandom_range(2 * NWORDS, 16'hFFFF));
                default: ra = 16'({$urandom_range(0, NWORDS - 1), 1'b0});
            endcase
            drive(1'($urandom_range(0, 99) < 60), ra,
                  1'($urandom_range(0, 99) < 10),
                  1'($urandom_range(0, 99) < 15),
                  16'({$urandom_range(0, NWORDS + 7), 1'($urandom_range(0, 9) == 0)}),
                  16'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                bus.ld_en = 1'b0;
                rst = 1'b0;
            end else begin
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b1;
        idle();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
Instruction-fetch responder: accepts fetch requests from the PC stage and returns the 16-bit instruction word after a fixed, parameterised latency. Raises a stall back to the PC stage while a fetch is in flight. Supports redirect flush from branch/jump resolution and a side port that loads program words before or between fetches. Sits between the PC register and the decode stage, holding the program store internally.

Parameters:
LATENCY, 2, cycles from request acceptance to rsp_valid (legal range 1..8).
DEPTH_LOG2, 10, log2 of the number of 16-bit words in the program store.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset; asserted when 0.
req_valid  in  1  fetch request present this cycle.
req_addr  in  16  byte address of the instruction.
flush  in  1  redirect; cancels any in-flight fetch and blocks acceptance this cycle.
ld_en  in  1  program-load write enable.
ld_addr  in  16  byte address for the load.
ld_data  in  16  word to store.
stall  out  1  PC-stage hold; drives the PC stall input.
rsp_valid  out  1  one-cycle pulse; rsp_instr is valid.
rsp_instr  out  16  fetched instruction word; 0 when rsp_valid=0.
rsp_addr  out  16  byte address of the returned instruction.
rsp_err  out  1  with rsp_valid: misaligned or out-of-range address.

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset (rst=0, asynchronous) forces IDLE, cnt=0, addr_q=0. All outputs read 0. Program store is not reset.
- Acceptance: in IDLE or DONE, with req_valid=1, flush=0 and ld_en=0, latch req_addr into addr_q.
  - LATENCY=1: next state DONE.
  - Otherwise: next state WAIT with cnt=LATENCY-2.
- WAIT: when cnt==0, go to DONE; otherwise decrement cnt.
- DONE: asserts rsp_valid. Accepts a new request in the same cycle, so back-to-back fetches are allowed. With no accept, goes to IDLE.
- Latency: acceptance at edge t gives rsp_valid=1 in the cycle after edge t+LATENCY-1. That is exactly LATENCY cycles after the request cycle.
- stall = (state==WAIT) | ld_en. stall is 0 in IDLE and DONE, and 0 during reset.
- rsp_valid = (state==DONE) & ~flush. A flush in the DONE cycle suppresses the response.
- Flush:
  - In WAIT: next state IDLE, no response produced.
  - In DONE: no accept; next state IDLE.
  - A flush and a req_valid in the same cycle: the request is dropped. The PC redirect re-presents it.
- Read timing: the store is read combinationally at addr_q[DEPTH_LOG2:1] during DONE.
  - A load to the same word in the DONE cycle returns the old word; the write lands at the edge.
  - Loads during WAIT are visible to the pending fetch.
- Errors: rsp_err=1 when addr_q[0]=1, or when addr_q[15:DEPTH_LOG2+1] is nonzero. In that case rsp_instr=0, rsp_addr=addr_q, and it is still a single rsp_valid pulse.
- Loads: ld_en writes ld_data at ld_addr[DEPTH_LOG2:1] at the clock edge.
  - Misaligned or out-of-range loads are ignored (no write).
  - ld_en has priority over acceptance and does not disturb an in-flight fetch.
- Reset mid-operation: the in-flight fetch is abandoned and there is no response after release.
- cnt width: 3 bits. Counts down only; no wrap.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'b00, WAIT=2'b01, DONE=2'b10);
  - INSTR_W=16;
  - ZERO_INSTR=16'h0000;
  - the address range-check helper.
- One sub-module, imem_array: a DEPTH-word by 16-bit store with one synchronous write port and one combinational read port.
- The FSM, latency counter and error check stay in fetch_responder.

Test Plan:
All tests use LATENCY=2 and DEPTH_LOG2=8.
1. Reset check: hold rst=0 for 3 cycles, then release -> stall=0, rsp_valid=0, rsp_instr=0, rsp_err=0.
2. Load then single fetch: load 0x0004<-16'hC123; request req_addr=0x0004 at cycle t -> stall=1 in t+1; rsp_valid=1, rsp_instr=16'hC123, rsp_addr=0x0004 in t+2; rsp_valid=0 in t+3.
3. Back-to-back fetch: request 0x0004 at t; request 0x0006 (preloaded 16'hA001) presented in DONE at t+2 -> responses at t+2 (C123) and t+4 (A001); stall=1 at t+1 and t+3 only.
4. Flush in WAIT: request 0x0004 at t; flush=1 at t+1 -> no rsp_valid at t+2; state IDLE; stall=0 at t+2.
5. Error cases:
   - Request 0x0005 -> rsp_valid=1, rsp_err=1, rsp_instr=0 at t+2.
   - Request 0x0200 -> rsp_err=1.
   - ld_en with ld_addr=0x0201 -> store unchanged.
6. Load during WAIT plus mid-op reset:
   - Request 0x0008 at t; ld 0x0008<-16'h5555 at t+1 -> rsp_instr=16'h5555 at t+2.
   - Separately, assert rst=0 at t+1 -> no response after release.
